tlul_sram_device_adapter: RTL and testbench

Device-side TL-UL adapter: accepts TL-UL channel A requests from the crossbar and converts them into a simple req/gnt/rvalid memory interface (SRAM or register file), then returns in-order channel D responses. It is the responder counterpart of the host adapter that turns core req/gnt into TL-UL. It tracks up to OUTSTANDING in-flight transactions, buffers read data against d_ready back-pressure, and answers protocol-illegal requests locally with d_error.

---
 rtl/tlul_sram_device_adapter.sv | 232 +++++++++++++++++++++++
 tb/tb_tlul_sram_device_adapter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_sram_device_adapter.sv
// TL-UL device adapter: turns channel A requests into an SRAM-style req/gnt/rvalid
// port and returns in-order channel D responses, answering illegal requests locally.

package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;

    typedef enum logic [2:0] {
        OP_PUT_FULL    = 3'h0,
        OP_PUT_PARTIAL = 3'h1,
        OP_GET         = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        OP_ACCESS_ACK      = 3'h0,
        OP_ACCESS_ACK_DATA = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_sram_device_adapter
    import tlul_pkg::*;
#(
    parameter int SRAM_AW     = 12,
    parameter int OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tl_h2d_t            tl_d_i,
    output tl_d2h_t            tl_d_o,
    output logic               req_o,
    input  logic               gnt_i,
    output logic               we_o,
    output logic [SRAM_AW-1:0] addr_o,
    output logic [TL_DW-1:0]   wdata_o,
    output logic [TL_DBW-1:0]  be_o,
    input  logic               rvalid_i,
    input  logic [TL_DW-1:0]   rdata_i,
    input  logic               rerr_i
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

    typedef struct packed {
        logic              is_write;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic              err;
    } info_t;

    typedef struct packed {
        logic [TL_DW-1:0] data;
        logic             err;
    } rdata_t;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // ---------------- request check ----------------
    logic              is_put;
    logic              op_ok;
    logic              size_ok;
    logic              align_ok;
    logic              mask_ok;
    logic              full_ok;
    logic              req_err;
    logic [TL_DBW-1:0] lane_mask;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_mask = '0;
        align_ok  = 1'b0;
        unique case (tl_d_i.a_size)
            2'd0: begin
                lane_mask = 4'b0001 << tl_d_i.a_address[1:0];
                align_ok  = 1'b1;
            end
            2'd1: begin
                lane_mask = tl_d_i.a_address[1] ? 4'b1100 : 4'b0011;
                align_ok  = ~tl_d_i.a_address[0];
            end
            2'd2: begin
                lane_mask = 4'b1111;
                align_ok  = (tl_d_i.a_address[1:0] == 2'b00);
            end
            default: begin
                lane_mask = 4'b1111;
                align_ok  = 1'b0;
            end
        endcase
    end

    assign is_put  = (tl_d_i.a_opcode == OP_PUT_FULL) || (tl_d_i.a_opcode == OP_PUT_PARTIAL);
    assign op_ok   = is_put || (tl_d_i.a_opcode == OP_GET);
    assign size_ok = (tl_d_i.a_size <= 2'd2);
    assign mask_ok = (tl_d_i.a_mask != '0) && ((tl_d_i.a_mask & ~lane_mask) == '0);
    assign full_ok = (tl_d_i.a_opcode != OP_PUT_FULL) || (tl_d_i.a_mask == lane_mask);
    assign req_err = ~(op_ok & size_ok & align_ok & mask_ok & full_ok);

    // ---------------- FIFO state ----------------
    info_t            info_mem [OUTSTANDING];
    rdata_t           data_mem [OUTSTANDING];
    logic [PTR_W-1:0] info_wr, info_rd, data_wr, data_rd;
    logic [CNT_W-1:0] info_cnt, data_cnt;

    logic   space;
    logic   a_accept;
    logic   data_push;
    logic   data_pop;
    logic   head_ready;
    logic   d_hs;
    info_t  head;
    rdata_t dhead;

    // The info FIFO occupancy is exactly the count of accepted, unanswered transactions.
    assign space    = (info_cnt < MAX_CNT);
    assign req_o    = ~rst_i & tl_d_i.a_valid & ~req_err & space;
    assign a_accept = tl_d_i.a_valid & tl_d_o.a_ready;

    assign head       = info_mem[info_rd];
    assign dhead      = data_mem[data_rd];
    assign head_ready = (info_cnt != '0) & (head.err | (data_cnt != '0));
    assign d_hs       = head_ready & tl_d_i.d_ready;
    assign data_pop   = d_hs & ~head.err;
    assign data_push  = rvalid_i & (info_cnt != '0) & (data_cnt != MAX_CNT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            info_wr  <= '0;
            info_rd  <= '0;
            info_cnt <= '0;
            data_wr  <= '0;
            data_rd  <= '0;
            data_cnt <= '0;
        end else begin
            if (a_accept) info_wr <= next_ptr(info_wr);
            if (d_hs)     info_rd <= next_ptr(info_rd);
            unique case ({a_accept, d_hs})
                2'b10:   info_cnt <= info_cnt + CNT_W'(1);
                2'b01:   info_cnt <= info_cnt - CNT_W'(1);
                default: info_cnt <= info_cnt;
            endcase

            if (data_push) data_wr <= next_ptr(data_wr);
            if (data_pop)  data_rd <= next_ptr(data_rd);
            unique case ({data_push, data_pop})
                2'b10:   data_cnt <= data_cnt + CNT_W'(1);
                2'b01:   data_cnt <= data_cnt - CNT_W'(1);
                default: data_cnt <= data_cnt;
            endcase
        end
    end

    // NOTE: storage arrays are not reset; the reset pointers and counts mark every entry invalid.
    always_ff @(posedge clk_i) begin
        if (a_accept) begin
            info_mem[info_wr] <= '{
                is_write: is_put,
                size:     tl_d_i.a_size,
                source:   tl_d_i.a_source,
                err:      req_err
            };
        end
        if (data_push) begin
            data_mem[data_wr] <= '{data: rdata_i, err: rerr_i};
        end
    end

    // ---------------- memory port ----------------
    assign we_o    = is_put;
    assign addr_o  = tl_d_i.a_address[SRAM_AW+1:2];
    assign wdata_o = tl_d_i.a_data;
    assign be_o    = tl_d_i.a_mask;

    logic unused_tl_bits;
    assign unused_tl_bits = ^{tl_d_i.a_param, tl_d_i.a_address[TL_AW-1:SRAM_AW+2]};

    // ---------------- channel D ----------------
    // Fields are forced to zero while no response is presented so stale entries never leak out.
    always_comb begin
        tl_d_o          = '0;
        tl_d_o.a_ready  = ~rst_i & space & (req_err | gnt_i);
        tl_d_o.d_valid  = head_ready;
        tl_d_o.d_opcode = OP_ACCESS_ACK;
        if (head_ready) begin
            tl_d_o.d_opcode = head.is_write ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA;
            tl_d_o.d_size   = head.size;
            tl_d_o.d_source = head.source;
            tl_d_o.d_error  = head.err | dhead.err;
            if (head.is_write) begin
                tl_d_o.d_data = '0;
            end else if (head.err) begin
                tl_d_o.d_data = '1;
            end else begin
                tl_d_o.d_data = dhead.data;
            end
        end
    end

endmodule

// File: tb/tb_tlul_sram_device_adapter.sv
// Self-checking bench for tlul_sram_device_adapter: request-check table, directed
// multi-cycle sequences, then randomized traffic against a transaction-level model.

module tb_tlul_sram_device_adapter;
    import tlul_pkg::*;

    localparam int SRAM_AW     = 12;
    localparam int OUTSTANDING = 2;
    localparam int RAND_CYCLES = 3000;

    logic               clk_i = 1'b0;
    logic               rst_i;
    tl_h2d_t            tl_i;
    tl_d2h_t            tl_o;
    logic               req, gnt, we, rvalid, rerr;
    logic [SRAM_AW-1:0] addr;
    logic [31:0]        wdata, rdata;
    logic [3:0]         be;

    always #5 clk_i = ~clk_i;

    tlul_sram_device_adapter #(.SRAM_AW(SRAM_AW), .OUTSTANDING(OUTSTANDING)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tl_d_i(tl_i), .tl_d_o(tl_o),
        .req_o(req), .gnt_i(gnt), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
        .rvalid_i(rvalid), .rdata_i(rdata), .rerr_i(rerr)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_d(input string name, input logic [2:0] op, input logic [1:0] sz,
                           input logic [7:0] src, input logic [31:0] data, input logic err);
        check(name,
              {tl_o.d_valid, tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source,
               tl_o.d_sink, tl_o.d_data, tl_o.d_error},
              {1'b1, op, 3'b000, sz, src, 1'b0, data, err});
    endtask

    task automatic put_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_param   = 3'b000;
        tl_i.a_size    = sz;
        tl_i.a_address = ad;
        tl_i.a_mask    = mk;
        tl_i.a_data    = dt;
        tl_i.a_source  = src;
    endtask

    task automatic clr_a();
        tl_i.a_valid = 1'b0;
    endtask

    // Advance to mid-cycle; the memory side is idle unless the caller drives a response.
    task automatic cyc();
        @(negedge clk_i);
        rvalid = 1'b0;
        rerr   = 1'b0;
        rdata  = '0;
    endtask

    task automatic rsp(input logic [31:0] d, input logic e);
        rvalid = 1'b1;
        rdata  = d;
        rerr   = e;
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [2:0] op, input int sz, input logic [31:0] ad,
                                     input logic [3:0] mk);
        int  nbytes;
        int  first;
        bit  e;
        bit  inside_lane;
        e = !(op == 3'h0 || op == 3'h1 || op == 3'h4);
        if (sz > 2) return 1'b1;
        nbytes = 1 << sz;
        first  = int'(ad[1:0]);
        if (first % nbytes != 0) e = 1'b1;
        if (mk == 4'h0) e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inside_lane = (i >= first) && (i < first + nbytes);
            if (mk[i] && !inside_lane) e = 1'b1;
            if (op == 3'h0 && inside_lane && !mk[i]) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic bad_word(input logic [11:0] a);
        return a[2:0] == 3'd5;
    endfunction

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        int          c;
    } grant_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic [31:0] sram    [4096];
    logic [31:0] ref_mem [4096];
    grant_t      gq[$];
    exp_t        eq[$];
    bit          acc_flag = 1'b0;

    task automatic gen_req();
        int          sz, low, nb;
        logic [2:0]  op;
        logic [3:0]  lanes, mk;
        logic [31:0] ad;
        case ($urandom_range(0, 2))
            0:       op = 3'h4;
            1:       op = 3'h0;
            default: op = 3'h1;
        endcase
        sz  = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, 2));
        low = int'($urandom_range(0, 63));
        if (sz < 3 && $urandom_range(0, 5) != 0) low = low - (low % (1 << sz));
        nb    = (sz < 3) ? (1 << sz) : 4;
        lanes = 4'((((1 << nb) - 1) << (low % 4)) & 15);
        if ($urandom_range(0, 7) == 0) begin
            mk = 4'($urandom_range(0, 15));
        end else if (op == 3'h0) begin
            mk = lanes;
        end else begin
            mk = lanes & 4'($urandom);
            if (mk == 4'h0) mk = lanes;
        end
        ad = ($urandom & 32'hFFFF_C000) | 32'(low);
        put_a(op, 2'(sz), ad, mk, $urandom, 8'($urandom));
    endtask

    task automatic rand_cycle(input bit gen, input int c);
        grant_t g;
        exp_t   x;
        logic   e, space, is_put;
        cyc();
        if (acc_flag) begin
            clr_a();
            acc_flag = 1'b0;
        end
        if (gq.size() > 0 && gq[0].c < c && (!gen || $urandom_range(0, 2) != 0)) begin
            g = gq.pop_front();
            if (g.we) begin
                for (int i = 0; i < 4; i++)
                    if (g.b[i]) sram[g.a][8*i +: 8] = g.d[8*i +: 8];
            end
            rsp(g.we ? $urandom : sram[g.a], bad_word(g.a));
        end
        gnt          = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        tl_i.d_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (gen && !tl_i.a_valid && $urandom_range(0, 9) < 7) gen_req();
        #1;
        e      = ref_err(tl_i.a_opcode, int'(tl_i.a_size), tl_i.a_address, tl_i.a_mask);
        is_put = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PARTIAL);
        space  = (eq.size() < OUTSTANDING);
        check("rnd_req", req, tl_i.a_valid && !e && space);
        if (tl_i.a_valid) check("rnd_a_ready", tl_o.a_ready, space && (e || gnt));
        if (tl_o.d_valid && tl_i.d_ready) begin
            if (eq.size() == 0) begin
                check("rnd_unexpected_d", tl_o.d_valid, 1'b0);
            end else begin
                x = eq.pop_front();
                check_d("rnd_resp", x.op, x.sz, x.src, x.data, x.err);
            end
        end
        if (tl_i.a_valid && space && (e || gnt)) begin
            x.op  = is_put ? 3'h0 : 3'h1;
            x.sz  = tl_i.a_size;
            x.src = tl_i.a_source;
            x.err = e ? 1'b1 : bad_word(tl_i.a_address[13:2]);
            if (is_put)  x.data = 32'h0;
            else if (e)  x.data = 32'hFFFF_FFFF;
            else         x.data = ref_mem[tl_i.a_address[13:2]];
            if (is_put && !e) begin
                for (int i = 0; i < 4; i++)
                    if (tl_i.a_mask[i])
                        ref_mem[tl_i.a_address[13:2]][8*i +: 8] = tl_i.a_data[8*i +: 8];
            end
            eq.push_back(x);
            acc_flag = 1'b1;
        end
        if (req && gnt) begin
            g = '{we: we, a: addr, d: wdata, b: be, c: c};
            gq.push_back(g);
        end
    endtask

    // ---------------- request-check table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [3:0]  mk;
        logic        err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sh;
        tbl[0]  = '{3'h4, 2'd2, 32'h0000_0010, 4'hF, 1'b0};
        tbl[1]  = '{3'h4, 2'd2, 32'h0000_0002, 4'hF, 1'b1};
        tbl[2]  = '{3'h4, 2'd3, 32'h0000_0000, 4'hF, 1'b1};
        tbl[3]  = '{3'h1, 2'd1, 32'h0000_0006, 4'hC, 1'b0};
        tbl[4]  = '{3'h1, 2'd1, 32'h0000_0006, 4'h3, 1'b1};
        tbl[5]  = '{3'h0, 2'd1, 32'h0000_0004, 4'h1, 1'b1};
        tbl[6]  = '{3'h0, 2'd2, 32'hA000_0100, 4'hF, 1'b0};
        tbl[7]  = '{3'h4, 2'd0, 32'h0000_0003, 4'h8, 1'b0};
        tbl[8]  = '{3'h4, 2'd0, 32'h0000_0003, 4'h0, 1'b1};
        tbl[9]  = '{3'h2, 2'd2, 32'h0000_0000, 4'hF, 1'b1};
        tbl[10] = '{3'h1, 2'd0, 32'h0000_0001, 4'h2, 1'b0};
        tbl[11] = '{3'h4, 2'd1, 32'h0000_0001, 4'h3, 1'b1};
        tbl[12] = '{3'h0, 2'd1, 32'h0000_000A, 4'hC, 1'b0};
        tbl[13] = '{3'h1, 2'd2, 32'h0000_0000, 4'h5, 1'b0};
        tbl[14] = '{3'h4, 2'd0, 32'h0000_0002, 4'h6, 1'b1};

        // Reset: a good request with a grant available must still see no req/a_ready.
        rst_i  = 1'b1;
        tl_i   = '0;
        gnt    = 1'b1;
        rvalid = 1'b0;
        rerr   = 1'b0;
        rdata  = '0;
        put_a(3'h4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd1);
        #1;
        check("reset_outputs", {tl_o.d_valid, tl_o.a_ready, req}, 3'b000);
        cyc();
        cyc();
        rst_i = 1'b0;
        clr_a();
        gnt   = 1'b0;
        #1;
        check("post_reset_idle", {tl_o.d_valid, req}, 2'b00);

        // Table: combinational request check; a_valid drops before the edge so nothing is accepted.
        for (int i = 0; i < 15; i++) begin
            cyc();
            put_a(tbl[i].op, tbl[i].sz, tbl[i].ad, tbl[i].mk, 32'h5555_AAAA, 8'(i));
            gnt = 1'b0;
            #1;
            sh = tbl[i].ad >> 2;
            check($sformatf("tbl%0d", i), {req, tl_o.a_ready, we, addr, be},
                  {~tbl[i].err, tbl[i].err, (tbl[i].op == 3'h0 || tbl[i].op == 3'h1), sh[11:0], tbl[i].mk});
            #2;
            clr_a();
        end

        // Single Get: response exactly two cycles after acceptance.
        cyc(); put_a(3'h4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3); gnt = 1'b1; tl_i.d_ready = 1'b1; #1;
        check("getA_req", {req, we, addr, tl_o.a_ready}, {1'b1, 1'b0, 12'h004, 1'b1});
        cyc(); clr_a(); gnt = 1'b0; rsp(32'hDEAD_BEEF, 1'b0); #1;
        check("getA_no_bypass", tl_o.d_valid, 1'b0);
        cyc(); #1;
        check_d("getA_resp", 3'h1, 2'd2, 8'd3, 32'hDEAD_BEEF, 1'b0);
        cyc(); #1;
        check("getA_done", tl_o.d_valid, 1'b0);

        // PutPartialData halfword.
        cyc(); put_a(3'h1, 2'd1, 32'h6, 4'hC, 32'h1234_0000, 8'd1); gnt = 1'b1; #1;
        check("putB_req", {req, we, be, wdata, addr}, {1'b1, 1'b1, 4'hC, 32'h1234_0000, 12'h001});
        cyc(); clr_a(); gnt = 1'b0; rsp(32'hAAAA_5555, 1'b0);
        cyc(); #1;
        check_d("putB_resp", 3'h0, 2'd1, 8'd1, 32'h0, 1'b0);

        // Misaligned Get sandwiched between two good Gets.
        cyc(); put_a(3'h4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd1); gnt = 1'b1; #1;
        check("C_g1_req", req, 1'b1);
        cyc(); put_a(3'h4, 2'd2, 32'h2, 4'hF, 32'h0, 8'd2); rsp(32'h1111_1111, 1'b0); #1;
        check("C_bad_noreq", {req, tl_o.a_ready, tl_o.d_valid}, 3'b010);
        cyc(); put_a(3'h4, 2'd2, 32'h24, 4'hF, 32'h0, 8'd4); #1;
        check_d("C_resp1", 3'h1, 2'd2, 8'd1, 32'h1111_1111, 1'b0);
        check("C_full", {req, tl_o.a_ready}, 2'b00);
        cyc(); #1;
        check_d("C_resp2", 3'h1, 2'd2, 8'd2, 32'hFFFF_FFFF, 1'b1);
        check("C_third_acc", {req, tl_o.a_ready}, 2'b11);
        cyc(); clr_a(); rsp(32'h3333_3333, 1'b0); #1;
        check("C_wait3", tl_o.d_valid, 1'b0);
        cyc(); #1;
        check_d("C_resp3", 3'h1, 2'd2, 8'd4, 32'h3333_3333, 1'b0);

        // Back-pressure: third Get held until the cycle after the first D-handshake.
        cyc(); tl_i.d_ready = 1'b0; put_a(3'h4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd5); #1;
        check("D_acc1", tl_o.a_ready, 1'b1);
        cyc(); put_a(3'h4, 2'd2, 32'h44, 4'hF, 32'h0, 8'd6); rsp(32'hA0A0_A0A0, 1'b0); #1;
        check("D_acc2", tl_o.a_ready, 1'b1);
        cyc(); put_a(3'h4, 2'd2, 32'h48, 4'hF, 32'h0, 8'd7); rsp(32'hB0B0_B0B0, 1'b0); #1;
        check("D_full_hold", {req, tl_o.a_ready}, 2'b00);
        check_d("D_resp1_wait", 3'h1, 2'd2, 8'd5, 32'hA0A0_A0A0, 1'b0);
        cyc(); #1;
        check("D_full_hold2", {req, tl_o.a_ready}, 2'b00);
        check_d("D_resp1_stable", 3'h1, 2'd2, 8'd5, 32'hA0A0_A0A0, 1'b0);
        cyc(); tl_i.d_ready = 1'b1; #1;
        check_d("D_resp1", 3'h1, 2'd2, 8'd5, 32'hA0A0_A0A0, 1'b0);
        check("D_no_reopen", {req, tl_o.a_ready}, 2'b00);
        cyc(); #1;
        check("D_reopen", {req, tl_o.a_ready}, 2'b11);
        check_d("D_resp2", 3'h1, 2'd2, 8'd6, 32'hB0B0_B0B0, 1'b0);
        cyc(); clr_a(); rsp(32'hC0C0_C0C0, 1'b0); #1;
        check("D_wait3", tl_o.d_valid, 1'b0);
        cyc(); #1;
        check_d("D_resp3", 3'h1, 2'd2, 8'd7, 32'hC0C0_C0C0, 1'b0);

        // Memory error on a write.
        cyc(); put_a(3'h0, 2'd2, 32'h8, 4'hF, 32'hCAFE_F00D, 8'd8); #1;
        check("E_req", {req, we, tl_o.a_ready}, 3'b111);
        cyc(); clr_a(); rsp(32'h0, 1'b1);
        cyc(); #1;
        check_d("E_rerr", 3'h0, 2'd2, 8'd8, 32'h0, 1'b1);

        // Reset with two outstanding Gets.
        cyc(); tl_i.d_ready = 1'b0; put_a(3'h4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd10); #1;
        cyc(); put_a(3'h4, 2'd2, 32'h34, 4'hF, 32'h0, 8'd11); rsp(32'h1, 1'b0); #1;
        cyc(); clr_a(); rsp(32'h2, 1'b0); #1;
        check("F_pending", tl_o.d_valid, 1'b1);
        cyc(); put_a(3'h4, 2'd2, 32'h38, 4'hF, 32'h0, 8'd12); rst_i = 1'b1; #1;
        check("F_in_reset", {tl_o.d_valid, tl_o.a_ready, req}, 3'b000);
        cyc(); rst_i = 1'b0; clr_a(); #1;
        check("F_released", tl_o.d_valid, 1'b0);
        cyc(); rsp(32'h7777_7777, 1'b0);
        cyc(); #1;
        check("F_stale_ignored", tl_o.d_valid, 1'b0);
        cyc(); tl_i.d_ready = 1'b1; put_a(3'h4, 2'd2, 32'h50, 4'hF, 32'h0, 8'd9); #1;
        check("F_next_acc", {req, tl_o.a_ready}, 2'b11);
        cyc(); clr_a(); rsp(32'h5A5A_5A5A, 1'b0);
        cyc(); #1;
        check_d("F_after", 3'h1, 2'd2, 8'd9, 32'h5A5A_5A5A, 1'b0);
        cyc();

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 4096; i++) begin
            sram[i]    = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        for (int c = 0; c < RAND_CYCLES; c++) rand_cycle(1'b1, c);
        for (int c = RAND_CYCLES; c < RAND_CYCLES + 400; c++) begin
            if (eq.size() == 0 && gq.size() == 0 && !tl_i.a_valid) break;
            rand_cycle(1'b0, c);
        end
        check("rnd_drain_empty", 64'(eq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
